fifo_axis_packer: RTL and testbench



---
 rtl/fifo_axis_packer.sv | 138 +++++++++++++
 tb/tb_fifo_axis_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_packer.sv
// Packs byte cells popped from the PS-PL FIFO into LANES-wide AXI4-Stream beats with periodic TLAST.
// Optional partial-word flush on idle timeout is built with `define PACKER_TIMEOUT_EN.
module fifo_axis_packer #(
  parameter int IN_W      = 8,
  parameter int LANES     = 4,
  parameter int PKT_BEATS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_valid,
  output logic                  fifo_enr,
  input  logic [IN_W-1:0]       fifo_data,
  output logic [IN_W*LANES-1:0] m_axis_tdata,
  output logic [LANES-1:0]      m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [15:0]           pkt_count
);

  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [15:0]   LAST_BEAT = 16'(PKT_BEATS - 1);

  typedef enum logic {FILL, SEND} state_e;

  state_e                       state_q;
  logic [LW-1:0]                lane_idx_q;
  logic [15:0]                  beat_idx_q;
  logic [15:0]                  pkt_cnt_q;
  logic [LANES-1:0][IN_W-1:0]   lanes_q;
  logic [LANES-1:0][IN_W-1:0]   word_d;
  logic [IN_W*LANES-1:0]        tdata_q;
  logic [LANES-1:0]             tkeep_q;
  logic                         tlast_q;
  logic                         pop;
  logic                         hs;

  assign fifo_enr      = fifo_valid && !rst && (state_q == FILL);
  assign pop           = fifo_enr;
  assign hs            = (state_q == SEND) && m_axis_tready;
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_count     = pkt_cnt_q;

  // The cell completing a word goes straight into the output register.
  always_comb begin
    word_d             = lanes_q;
    word_d[lane_idx_q] = fifo_data;
  end

`ifdef PACKER_TIMEOUT_EN
  logic [15:0]      idle_cnt_q;
  logic             partial_q;
  logic             timeout_hit;
  logic [LANES-1:0] keep_part;

  assign timeout_hit = (state_q == FILL) && !pop && (lane_idx_q != '0) &&
                       (idle_cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    keep_part = '0;
    for (int i = 0; i < LANES; i++) keep_part[i] = (i < int'(lane_idx_q));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      lane_idx_q <= '0;
      beat_idx_q <= '0;
      pkt_cnt_q  <= '0;
      lanes_q    <= '0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
`ifdef PACKER_TIMEOUT_EN
      idle_cnt_q <= '0;
      partial_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (pop) begin
            lanes_q[lane_idx_q] <= fifo_data;
            lane_idx_q          <= lane_idx_q + 1'b1;
`ifdef PACKER_TIMEOUT_EN
            idle_cnt_q          <= '0;
`endif
            if (lane_idx_q == LAST_LANE) begin
              state_q <= SEND;
              tdata_q <= word_d;
              tkeep_q <= '1;
              tlast_q <= (beat_idx_q == LAST_BEAT);
              lanes_q <= '0;
            end
          end
`ifdef PACKER_TIMEOUT_EN
          // Unused lanes are already zero: the lane store is cleared whenever a beat leaves.
          else if (timeout_hit) begin
            state_q    <= SEND;
            tdata_q    <= lanes_q;
            tkeep_q    <= keep_part;
            tlast_q    <= 1'b1;
            partial_q  <= 1'b1;
            lanes_q    <= '0;
            idle_cnt_q <= '0;
          end else if (lane_idx_q != '0) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end
        SEND: begin
          if (hs) begin
            state_q <= FILL;
`ifdef PACKER_TIMEOUT_EN
            partial_q  <= 1'b0;
            lane_idx_q <= '0;
            if (partial_q || (beat_idx_q == LAST_BEAT)) begin
`else
            if (beat_idx_q == LAST_BEAT) begin
`endif
              beat_idx_q <= '0;
              pkt_cnt_q  <= pkt_cnt_q + 1'b1;
            end else begin
              beat_idx_q <= beat_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Directed bench for fifo_axis_packer: a cycle-vector table plus hand-written corner sequences.
// A second instance with PKT_BEATS=2 checks TLAST placement and packet counting.
module tb_fifo_axis_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_valid;
  logic [7:0]  fifo_data;
  logic        m_axis_tready;
  logic        fifo_enr, fifo_enr2;
  logic [31:0] tdata, tdata2;
  logic [3:0]  tkeep, tkeep2;
  logic        tlast, tlast2, tvalid, tvalid2;
  logic [15:0] pkt_count, pkt_count2;

  always #5 clk = ~clk;

  fifo_axis_packer #(.IN_W(8), .LANES(4), .PKT_BEATS(16), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_enr(fifo_enr), .fifo_data(fifo_data),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(m_axis_tready), .pkt_count(pkt_count));

  fifo_axis_packer #(.IN_W(8), .LANES(4), .PKT_BEATS(2), .TIMEOUT(10)) dut2 (
    .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_enr(fifo_enr2), .fifo_data(fifo_data),
    .m_axis_tdata(tdata2), .m_axis_tkeep(tkeep2), .m_axis_tlast(tlast2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(m_axis_tready), .pkt_count(pkt_count2));

  typedef struct packed {
    logic        r, v;
    logic [7:0]  d;
    logic        rdy, e_enr, e_vld, chk;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        e_last;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_pop = 0;
  logic       gate = 1'b1;
  logic [7:0] q[$];
  beat_t      cap1[$];
  beat_t      cap2[$];
  vec_t       tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle with a queue-backed FIFO model; entered and left at the falling edge.
  task automatic cycle();
    logic popped;
    fifo_valid = gate && (q.size() > 0);
    fifo_data  = (q.size() > 0) ? q[0] : 8'h00;
    #1;
    popped = fifo_enr && fifo_valid;
    if (tvalid && m_axis_tready)  cap1.push_back('{tdata, tkeep, tlast});
    if (tvalid2 && m_axis_tready) cap2.push_back('{tdata2, tkeep2, tlast2});
    @(posedge clk);
    if (popped) begin
      void'(q.pop_front());
      last_pop = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    cycle();
    rst = 1'b0;
    cap1.delete();
    cap2.delete();
  endtask

  initial begin
    rst = 1'b1; fifo_valid = 1'b0; fifo_data = 8'h00; m_axis_tready = 1'b1;
    //            r     v     d      rdy   enr   vld   chk   data          keep  last
    tbl[0]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000000, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};

    @(negedge clk);
    @(negedge clk);

    // Vector table: reset values, then two full beats with pop-to-valid latency of one cycle.
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].r; fifo_valid = tbl[i].v; fifo_data = tbl[i].d; m_axis_tready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d enr", i), 32'(fifo_enr), 32'(tbl[i].e_enr));
      chk($sformatf("vec%0d tvalid", i), 32'(tvalid), 32'(tbl[i].e_vld));
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d tdata", i), tdata, tbl[i].e_data);
        chk($sformatf("vec%0d tkeep", i), 32'(tkeep), 32'(tbl[i].e_keep));
        chk($sformatf("vec%0d tlast", i), 32'(tlast), 32'(tbl[i].e_last));
      end
      if (i == 0) chk("reset pkt_count", 32'(pkt_count), 32'd0);
      @(negedge clk);
    end
    chk("vec pkt_count", 32'(pkt_count), 32'd0);

    // PKT_BEATS=2: tlast on beats 2 and 4, two packets.
    m_axis_tready = 1'b1;
    do_reset();
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));
    for (int i = 0; i < 25; i++) cycle();
    chk("pkt2 beats", 32'(cap2.size()), 32'd4);
    for (int b = 0; b < 4 && b < cap2.size(); b++) begin
      chk($sformatf("pkt2 beat%0d data", b), cap2[b].d,
          {8'(4*b+4), 8'(4*b+3), 8'(4*b+2), 8'(4*b+1)});
      chk($sformatf("pkt2 beat%0d last", b), 32'(cap2[b].l), 32'(b % 2));
    end
    chk("pkt2 pkt_count", 32'(pkt_count2), 32'd2);

    // Backpressure: beat pending for 20 cycles with tready low.
    m_axis_tready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'h21 + 8'(i));
    for (int k = 0; k < 20 && !tvalid; k++) cycle();
    chk("bp tvalid", 32'(tvalid), 32'd1);
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk($sformatf("bp hold%0d", k), {tdata[27:0], tkeep}, {28'h4232221, 4'hF});
      chk($sformatf("bp hold%0d last/enr/tvalid", k), {tlast, fifo_enr, tvalid}, 32'b001);
    end
    chk("bp fifo depth", 32'(q.size()), 32'd4);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    chk("bp beats", 32'(cap1.size()), 32'd2);
    if (cap1.size() == 2) begin
      chk("bp beat0", cap1[0].d, 32'h24232221);
      chk("bp beat1", cap1[1].d, 32'h28272625);
    end

    // fifo_valid toggling every other cycle.
    do_reset();
    for (int i = 0; i < 12; i++) q.push_back(8'h31 + 8'(i));
    for (int k = 0; k < 50; k++) begin
      gate = ~gate;
      cycle();
    end
    gate = 1'b1;
    chk("gap beats", 32'(cap1.size()), 32'd3);
    for (int b = 0; b < 3 && b < cap1.size(); b++)
      chk($sformatf("gap beat%0d", b), cap1[b].d,
          {8'h34 + 8'(4*b), 8'h33 + 8'(4*b), 8'h32 + 8'(4*b), 8'h31 + 8'(4*b)});

    // Reset with a pending beat drops tvalid on the next cycle.
    m_axis_tready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'hC0 + 8'(i));
    for (int k = 0; k < 6; k++) cycle();
    chk("rst pending tvalid before", 32'(tvalid), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst pending tvalid after", 32'(tvalid), 32'd0);

    // Reset after two of four cells: partial word discarded.
    m_axis_tready = 1'b1;
    do_reset();
    q.push_back(8'h55); q.push_back(8'h66);
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst mid tvalid", 32'(tvalid), 32'd0);
    for (int i = 0; i < 4; i++) q.push_back(8'hA0 + 8'(i));
    for (int k = 0; k < 10; k++) cycle();
    chk("rst mid beats", 32'(cap1.size()), 32'd1);
    if (cap1.size() > 0) chk("rst mid data", cap1[0].d, 32'hA3A2A1A0);

`ifdef PACKER_TIMEOUT_EN
    // Idle timeout flushes a 3-cell partial beat 11 cycles after the last pop.
    m_axis_tready = 1'b0;
    do_reset();
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    cycle(); cycle(); cycle();
    for (int k = 0; k < 40 && !tvalid; k++) cycle();
    chk("tmo tvalid", 32'(tvalid), 32'd1);
    chk("tmo delay", 32'(cyc - last_pop), 32'd11);
    chk("tmo tdata", tdata, 32'h00332211);
    chk("tmo tkeep", 32'(tkeep), 32'h7);
    chk("tmo tlast", 32'(tlast), 32'd1);
    m_axis_tready = 1'b1;
    cycle();
    chk("tmo pkt_count", 32'(pkt_count), 32'd1);
    chk("tmo tvalid after", 32'(tvalid), 32'd0);
`else
    // Without the timeout a partial word is never emitted.
    m_axis_tready = 1'b1;
    do_reset();
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    for (int k = 0; k < 1000; k++) cycle();
    chk("no tmo beats", 32'(cap1.size()), 32'd0);
    chk("no tmo pkt_count", 32'(pkt_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
